uart_tx_engine: RTL and testbench

UART transmit serializer that sits directly downstream of the TX FIFO_Buffer and drains it.
- Pops one word per frame through the FIFO read port. FIFO dataOut is registered, so it is valid the cycle after readEn.
- Serializes each word onto the tx line: start bit, DWIDTH data bits LSB first, optional parity bit, stop bit(s).
- Baud timing comes from an internal clocks-per-bit counter.

---
 rtl/uart_tx_engine.sv | 147 ++++++++++++++
 tb/tb_uart_tx_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit serializer draining a registered-output TX FIFO: one pop per frame,
// start bit, LSB-first data, optional parity, then one or two stop bits.
module uart_tx_engine #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DWIDTH       = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_enable,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IW = $clog2(DWIDTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DWIDTH - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DWIDTH-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              baud_last;

    assign baud_last = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (tx_enable && !fifo_empty) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                shift_d  = fifo_data;
                parity_d = (^fifo_data) ^ (PARITY_ODD != 0);
                baud_d   = '0;
                idx_d    = '0;
                state_d  = S_START;
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // tx is registered, so it is driven from the state being entered
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign fifo_rd_en = (state_q == S_FETCH);
    assign busy       = (state_q != S_IDLE);
    assign tx_done    = (state_q == S_STOP) && baud_last && (idx_q == STOP_LAST);
    assign tx         = tx_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: three configurations fed by queue-based FIFO models,
// each frame compared bit-by-bit with a waveform built from the frame format rules.
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] en;
    logic [2:0] empty;
    logic [7:0] d0, d1, d2;
    logic [2:0] rd, txo, bsy, dn;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic       fbits[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int viol = 0;
    int idle_seen, rd_cyc, start_cyc, end_cyc;

    always #5 clk = ~clk;

    uart_tx_engine #(.CLKS_PER_BIT(4), .DWIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .reset(rst), .tx_enable(en[0]), .fifo_empty(empty[0]), .fifo_data(d0),
        .fifo_rd_en(rd[0]), .tx(txo[0]), .busy(bsy[0]), .tx_done(dn[0]));

    uart_tx_engine #(.CLKS_PER_BIT(4), .DWIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .clk(clk), .reset(rst), .tx_enable(en[1]), .fifo_empty(empty[1]), .fifo_data(d1),
        .fifo_rd_en(rd[1]), .tx(txo[1]), .busy(bsy[1]), .tx_done(dn[1]));

    uart_tx_engine #(.CLKS_PER_BIT(3), .DWIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
        .clk(clk), .reset(rst), .tx_enable(en[2]), .fifo_empty(empty[2]), .fifo_data(d2),
        .fifo_rd_en(rd[2]), .tx(txo[2]), .busy(bsy[2]), .tx_done(dn[2]));

    function automatic int cfg_cpb(int i);
        return (i == 2) ? 3 : 4;
    endfunction
    function automatic int cfg_pen(int i);
        return (i == 0) ? 0 : 1;
    endfunction
    function automatic int cfg_podd(int i);
        return (i == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_sb(int i);
        return (i == 2) ? 2 : 1;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: FIFO model pops on readEn (registered dataOut), otherwise dataOut wanders
    task automatic step();
        logic [2:0] pop;
        pop = rd;
        @(posedge clk);
        #1;
        cyc++;
        if (pop[0] && q0.size() > 0) d0 = q0.pop_front(); else d0 = 8'($urandom);
        if (pop[1] && q1.size() > 0) d1 = q1.pop_front(); else d1 = 8'($urandom);
        if (pop[2] && q2.size() > 0) d2 = q2.pop_front(); else d2 = 8'($urandom);
        empty = {q2.size() == 0, q1.size() == 0, q0.size() == 0};
        if ((rd & empty) != 3'b000) viol++;
    endtask

    task automatic push(int i, logic [7:0] d);
        case (i)
            0: q0.push_back(d);
            1: q1.push_back(d);
            default: q2.push_back(d);
        endcase
        empty[i] = 1'b0;
    endtask

    task automatic build(int i, logic [7:0] d);
        int ones;
        ones = 0;
        fbits.delete();
        fbits.push_back(1'b0);
        for (int k = 0; k < 8; k++) begin
            fbits.push_back(d[k]);
            ones += int'(d[k]);
        end
        if (cfg_pen(i) != 0)
            fbits.push_back((cfg_podd(i) != 0) ? ((ones % 2) == 0) : ((ones % 2) == 1));
        for (int s = 0; s < cfg_sb(i); s++) fbits.push_back(1'b1);
    endtask

    task automatic run_frame(int i, logic [7:0] d, int drop_bit);
        int k, ok, ndone, done_off, cpb, nb;
        cpb = cfg_cpb(i);
        k = 0;
        idle_seen = 0;
        while (rd[i] !== 1'b1 && k < 80) begin
            step();
            k++;
            if (bsy[i] === 1'b0) idle_seen++;
        end
        chk($sformatf("u%0d_fetch_seen", i), int'(rd[i]), 1);
        rd_cyc = cyc;
        step();
        chk($sformatf("u%0d_load_tx_rd_busy", i), int'({txo[i], rd[i], bsy[i]}), 5);
        step();
        start_cyc = cyc;
        build(i, d);
        nb = fbits.size();
        ndone = 0;
        done_off = -1;
        for (int b = 0; b < nb; b++) begin
            ok = 0;
            if (b == drop_bit) en[i] = 1'b0;
            for (int c = 0; c < cpb; c++) begin
                if (b != 0 || c != 0) step();
                if (txo[i] === fbits[b] && bsy[i] === 1'b1 && rd[i] === 1'b0) ok++;
                if (dn[i] === 1'b1) begin
                    ndone++;
                    done_off = cyc - start_cyc;
                end
            end
            chk($sformatf("u%0d_data%02h_bit%0d", i, d, b), ok, cpb);
        end
        chk($sformatf("u%0d_done_count", i), ndone, 1);
        chk($sformatf("u%0d_done_offset", i), done_off, nb * cpb - 1);
        end_cyc = cyc;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int nrd, ntx, nbusy, ndone, p, e;
        logic [7:0] r[4];

        rst = 1'b1;
        en = 3'b000;
        empty = 3'b111;
        d0 = '0; d1 = '0; d2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", int'(txo), 7);
        chk("reset_busy", int'(bsy), 0);
        chk("reset_rd_en", int'(rd), 0);
        chk("reset_done", int'(dn), 0);
        rst = 1'b0;
        step();

        // Enabled but empty: nothing may move
        en = 3'b111;
        nrd = 0; ntx = 0; nbusy = 0;
        repeat (100) begin
            step();
            if (rd !== 3'b000) nrd++;
            if (txo !== 3'b111) ntx++;
            if (bsy !== 3'b000) nbusy++;
        end
        chk("empty_no_rd_en", nrd, 0);
        chk("empty_tx_high", ntx, 0);
        chk("empty_not_busy", nbusy, 0);

        en = 3'b001;
        push(0, 8'hA5);
        p = cyc;
        run_frame(0, 8'hA5, -1);
        chk("a5_latency", start_cyc - p, 3);
        step();
        chk("a5_after_idle", int'({txo[0], bsy[0], rd[0]}), 4);

        push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
        run_frame(0, 8'h01, -1);
        for (int n = 2; n <= 3; n++) begin
            e = end_cyc;
            run_frame(0, 8'(n), -1);
            chk($sformatf("b2b_gap_%0d", n), start_cyc - e - 1, 3);
            chk($sformatf("b2b_idle_busy_low_%0d", n), idle_seen, 1);
        end
        chk("b2b_fifo_drained", q0.size(), 0);

        en = 3'b010;
        push(1, 8'h07);
        run_frame(1, 8'h07, -1);
        en = 3'b100;
        push(2, 8'h07);
        run_frame(2, 8'h07, -1);

        for (int i = 0; i < 3; i++) begin
            en = 3'b000;
            en[i] = 1'b1;
            repeat ($urandom_range(1, 6)) step();
            for (int n = 0; n < 4; n++) begin
                r[n] = 8'($urandom);
                push(i, r[n]);
            end
            for (int n = 0; n < 4; n++) begin
                e = end_cyc;
                run_frame(i, r[n], -1);
                if (n > 0) chk($sformatf("u%0d_rand_gap_%0d", i, n), start_cyc - e - 1, 3);
            end
        end

        // Enable dropped in data bit 3: frame finishes, second word stays queued
        en = 3'b001;
        repeat (3) step();
        push(0, 8'h3C); push(0, 8'h99);
        run_frame(0, 8'h3C, 4);
        nrd = 0;
        repeat (60) begin
            step();
            if (rd[0] !== 1'b0) nrd++;
        end
        chk("drop_no_more_rd_en", nrd, 0);
        chk("drop_word_retained", q0.size(), 1);
        chk("drop_idle", int'({txo[0], bsy[0]}), 2);
        en[0] = 1'b1;
        run_frame(0, 8'h99, -1);

        // Reset in data bit 5: immediate idle line, popped word lost
        repeat (2) step();
        push(0, 8'h5A); push(0, 8'hC3);
        p = 0;
        while (rd[0] !== 1'b1 && p < 80) begin
            step();
            p++;
        end
        chk("rst_test_fetch_seen", int'(rd[0]), 1);
        step();
        step();
        ndone = 0;
        repeat (6 * 4 + 1) begin
            step();
            if (dn[0] === 1'b1) ndone++;
        end
        chk("rst_test_tx_is_bit5", int'(txo[0]), 0);
        #2 rst = 1'b1;
        #1;
        chk("midreset_tx_busy_rd", int'({txo[0], bsy[0], rd[0]}), 4);
        chk("midreset_no_done", ndone + int'(dn[0]), 0);
        step();
        rst = 1'b0;
        p = cyc;
        run_frame(0, 8'hC3, -1);
        chk("post_reset_latency", start_cyc - p, 3);

        chk("never_rd_en_while_empty", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
